// File: rtl/proj_pkg.sv
// Shared constants and types for the k-mer front end of proj_hasher.
package proj_pkg;

  localparam int unsigned KMER_LEN                = 4;
  localparam int unsigned BASE_LEN                = 2;
  localparam int unsigned HASHER_SORTER_SIGNATURE = 32;
  localparam int unsigned POS_BITS                = 16;

  typedef enum logic [BASE_LEN-1:0] {
    A = 2'd0,
    C = 2'd1,
    G = 2'd2,
    T = 2'd3
  } base_t;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } kx_state_t;

endpackage

// File: rtl/proj_kmer_revcomp.sv
// Reverse-complement window shift and canonical (min) k-mer select.
// Compiled only when PROJ_CANONICAL_KMER_EN is defined, so the default build carries no rc logic.
`ifdef PROJ_CANONICAL_KMER_EN
module proj_kmer_revcomp
  import proj_pkg::*;
#(
  parameter int unsigned DATA_BITS = proj_pkg::BASE_LEN,
  parameter int unsigned W         = proj_pkg::KMER_LEN * proj_pkg::BASE_LEN
) (
  input  logic [W-1:0]         window_next,
  input  logic [W-1:0]         rc,
  input  logic [DATA_BITS-1:0] base,
  output logic [W-1:0]         rc_next,
  output logic [W-1:0]         canon
);

  // Complemented base enters at the MSBs so rc reads as the reversed strand.
  assign rc_next = {~base, rc[W-1:DATA_BITS]};
  assign canon   = (rc_next < window_next) ? rc_next : window_next;

endmodule
`endif

// File: rtl/proj_kmer_extractor.sv
// Sliding-window k-mer extractor feeding proj_hasher; one registered valid/ready output stage.
// Optional canonical k-mer output (min of forward and reverse complement) under PROJ_CANONICAL_KMER_EN.
module proj_kmer_extractor
  import proj_pkg::*;
#(
  parameter int unsigned KMER_LEN         = proj_pkg::KMER_LEN,
  parameter int unsigned DATA_BITS        = proj_pkg::BASE_LEN,
  parameter int unsigned HASHER_DATA_BITS = proj_pkg::HASHER_SORTER_SIGNATURE,
  parameter int unsigned POS_BITS         = proj_pkg::POS_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        base_valid,
  output logic                        base_ready,
  input  logic [DATA_BITS-1:0]        base,
  input  logic                        base_last,
  output logic                        kmer_valid,
  input  logic                        kmer_ready,
  output logic [HASHER_DATA_BITS-1:0] kmer,
  output logic [POS_BITS-1:0]         kmer_pos,
  output logic                        kmer_last,
  output logic                        seq_short
);

  localparam int unsigned W     = KMER_LEN * DATA_BITS;
  localparam int unsigned CNT_W = $clog2(KMER_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KMER_LEN - 1);

  kx_state_t                   state;
  logic [CNT_W-1:0]            fill_cnt;
  logic [POS_BITS-1:0]         pos_cnt;
  logic [W-1:0]                window;
  logic [W-1:0]                window_next;
  logic [HASHER_DATA_BITS-1:0] kmer_next;
  logic                        accept;
  logic                        emit;

  assign base_ready  = !kmer_valid || kmer_ready;
  assign accept      = base_valid && base_ready;
  assign window_next = {window[W-DATA_BITS-1:0], base};
  // The KMER_LEN-th base of a fill already completes a k-mer.
  assign emit        = (state == ST_STREAM) || (fill_cnt == CNT_FULL);

`ifdef PROJ_CANONICAL_KMER_EN
  logic [W-1:0] rc;
  logic [W-1:0] rc_next;
  logic [W-1:0] canon;

  proj_kmer_revcomp #(
    .DATA_BITS (DATA_BITS),
    .W         (W)
  ) u_revcomp (
    .window_next (window_next),
    .rc          (rc),
    .base        (base),
    .rc_next     (rc_next),
    .canon       (canon)
  );

  assign kmer_next = HASHER_DATA_BITS'(canon);

  // Reverse-complement window tracks the forward window, cleared at sequence end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc <= '0;
    end else if (accept) begin
      rc <= base_last ? '0 : rc_next;
    end
  end
`else
  assign kmer_next = HASHER_DATA_BITS'(window_next);
`endif

  // Fill/stream control and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      fill_cnt   <= '0;
      pos_cnt    <= '0;
      window     <= '0;
      kmer_valid <= 1'b0;
      kmer       <= '0;
      kmer_pos   <= '0;
      kmer_last  <= 1'b0;
      seq_short  <= 1'b0;
    end else begin
      seq_short <= 1'b0;
      if (kmer_valid && kmer_ready) begin
        kmer_valid <= 1'b0;
      end
      if (accept) begin
        if (emit) begin
          kmer_valid <= 1'b1;
          kmer       <= kmer_next;
          kmer_pos   <= pos_cnt;
          kmer_last  <= base_last;
        end else if (base_last) begin
          seq_short <= 1'b1;
        end
        if (base_last) begin
          state    <= ST_FILL;
          fill_cnt <= '0;
          pos_cnt  <= '0;
          window   <= '0;
        end else begin
          window <= window_next;
          if (emit) begin
            state   <= ST_STREAM;
            pos_cnt <= pos_cnt + POS_BITS'(1);
          end else begin
            fill_cnt <= fill_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_proj_kmer_extractor.sv
// Self-checking bench for proj_kmer_extractor: directed table, hand sequences, random traffic vs a k-mer model.
module tb_proj_kmer_extractor;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        base_valid;
  logic        base_ready;
  logic [1:0]  base;
  logic        base_last;
  logic        kmer_valid;
  logic        kmer_ready = 1'b1;
  logic [31:0] kmer;
  logic [15:0] kmer_pos;
  logic        kmer_last;
  logic        seq_short;

  always #5 clk = ~clk;

  proj_kmer_extractor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .base_valid (base_valid),
    .base_ready (base_ready),
    .base       (base),
    .base_last  (base_last),
    .kmer_valid (kmer_valid),
    .kmer_ready (kmer_ready),
    .kmer       (kmer),
    .kmer_pos   (kmer_pos),
    .kmer_last  (kmer_last),
    .seq_short  (seq_short)
  );

  typedef struct packed {
    logic [31:0] kmer;
    logic [15:0] pos;
    logic        last;
  } kout_t;

  typedef struct packed {
    logic [63:0] seq;
    logic [7:0]  len;
    logic [7:0]  n;
    logic [31:0] first_f;
    logic [31:0] last_f;
    logic [31:0] first_c;
    logic [31:0] last_c;
    logic [7:0]  nshort;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
  int short_cnt = 0;
  int exp_short = 0;

  kout_t      got[$];
  kout_t      exp_q[$];
  logic [1:0] seq_tmp[$];
  logic [1:0] sb[$];
  bit         sl[$];
  vec_t       vecs[6];

  // Transfers and pulses are sampled mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kmer_valid && kmer_ready) got.push_back({kmer, kmer_pos, kmer_last});
      if (seq_short) short_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       kmer_ready = 1'b1;
      1:       kmer_ready = ($urandom_range(3) != 0);
      default: kmer_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: every window position of seq_tmp, with optional canonical min.
  task automatic add_seq();
    int n;
    n = seq_tmp.size();
    for (int i = 0; i < n; i++) begin
      sb.push_back(seq_tmp[i]);
      sl.push_back(i == n - 1);
    end
    if (n < K) begin
      exp_short++;
    end else begin
      for (int i = 0; i <= n - K; i++) begin
        int f;
        int r;
        f = 0;
        r = 0;
        for (int j = 0; j < K; j++) begin
          int bv;
          bv = int'(seq_tmp[i+j]);
          f = f * 4 + bv;
          r = r + ((3 - bv) << (2 * j));
        end
`ifdef PROJ_CANONICAL_KMER_EN
        if (r < f) f = r;
`endif
        exp_q.push_back({32'(f), 16'(i), (i == n - K)});
      end
    end
    seq_tmp.delete();
  endtask

  task automatic str_to_seq(input logic [63:0] s, input int len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] ch;
      ch = s[8*(len-1-i) +: 8];
      case (ch)
        "A":     seq_tmp.push_back(2'd0);
        "C":     seq_tmp.push_back(2'd1);
        "G":     seq_tmp.push_back(2'd2);
        default: seq_tmp.push_back(2'd3);
      endcase
    end
  endtask

  // Drives all queued bases (entered and left at posedge+1), then drains the output stage.
  task automatic run(input string name, input int gap_pct);
    int budget;
    int cycles;
    bit acc;
    budget = 4 * sb.size() + 200;
    cycles = 0;
    while (sb.size() > 0) begin
      if ($urandom_range(99) < gap_pct) begin
        base_valid = 1'b0;
        @(posedge clk); #1;
        cycles++;
      end
      base_valid = 1'b1;
      base       = sb[0];
      base_last  = sl[0];
      @(negedge clk);
      acc = base_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) begin
        void'(sb.pop_front());
        void'(sl.pop_front());
      end
      if (cycles > budget) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: %0d bases still pending, required 0", name, sb.size());
        sb.delete();
        sl.delete();
      end
    end
    base_valid = 1'b0;
    base_last  = 1'b0;
    for (int c = 0; c < 64 && kmer_valid; c++) begin
      @(posedge clk); #1;
    end
    if (kmer_valid) begin
      total++;
      bad++;
      $display("FAIL %s_drain: kmer_valid still 1, required 0", name);
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic compare_all(input string name);
    int diff;
    diff = -1;
    total++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i] && diff < 0) diff = i;
    if (diff >= 0) begin
      bad++;
      $display("FAIL %s: entry %0d got kmer=0x%0h pos=%0d last=%0b, expected kmer=0x%0h pos=%0d last=%0b",
               name, diff, got[diff].kmer, got[diff].pos, got[diff].last,
               exp_q[diff].kmer, exp_q[diff].pos, exp_q[diff].last);
    end else if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s: got %0d k-mers, expected %0d", name, got.size(), exp_q.size());
    end
    check({name, "_short"}, 32'(short_cnt), 32'(exp_short));
    got.delete();
    exp_q.delete();
    short_cnt = 0;
    exp_short = 0;
  endtask

  initial begin
    vecs[0] = '{64'("ACGTA"), 8'd5, 8'd2, 32'h1B, 32'h6C, 32'h1B, 32'h6C, 8'd0};
    vecs[1] = '{64'("ACG"),   8'd3, 8'd0, 32'h00, 32'h00, 32'h00, 32'h00, 8'd1};
    vecs[2] = '{64'("TTTT"),  8'd4, 8'd1, 32'hFF, 32'hFF, 32'h00, 32'h00, 8'd0};
    vecs[3] = '{64'("GGGGC"), 8'd5, 8'd2, 32'hAA, 32'hA9, 32'h55, 32'h95, 8'd0};
    vecs[4] = '{64'("CA"),    8'd2, 8'd0, 32'h00, 32'h00, 32'h00, 32'h00, 8'd1};
    vecs[5] = '{64'("TGCA"),  8'd4, 8'd1, 32'hE4, 32'hE4, 32'hE4, 32'hE4, 8'd0};

    rst_n      = 1'b0;
    base_valid = 1'b0;
    base       = 2'd0;
    base_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(kmer_valid), 32'd0);
    check("rst_kmer", kmer, 32'd0);
    check("rst_pos", 32'(kmer_pos), 32'd0);
    check("rst_last", 32'(kmer_last), 32'd0);
    check("rst_short", 32'(seq_short), 32'd0);
    check("rst_base_ready", 32'(base_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, one sequence per run.
    for (int v = 0; v < 6; v++) begin
      logic [31:0] ef;
      logic [31:0] el;
`ifdef PROJ_CANONICAL_KMER_EN
      ef = vecs[v].first_c;
      el = vecs[v].last_c;
`else
      ef = vecs[v].first_f;
      el = vecs[v].last_f;
`endif
      str_to_seq(vecs[v].seq, int'(vecs[v].len));
      add_seq();
      run($sformatf("vec%0d", v), 0);
      check($sformatf("vec%0d_count", v), 32'(got.size()), 32'(vecs[v].n));
      check($sformatf("vec%0d_nshort", v), 32'(short_cnt), 32'(vecs[v].nshort));
      if (got.size() > 0) begin
        check($sformatf("vec%0d_first", v), got[0].kmer, ef);
        check($sformatf("vec%0d_first_pos", v), 32'(got[0].pos), 32'd0);
        check($sformatf("vec%0d_last", v), got[got.size()-1].kmer, el);
        check($sformatf("vec%0d_last_flag", v), 32'(got[got.size()-1].last), 32'd1);
      end
      compare_all($sformatf("vec%0d_model", v));
    end

    // Short sequence immediately followed by a full one.
    str_to_seq(64'("ACG"), 3);
    add_seq();
    str_to_seq(64'("TTTT"), 4);
    add_seq();
    run("b2b", 0);
    check("b2b_count", 32'(got.size()), 32'd1);
    check("b2b_nshort", 32'(short_cnt), 32'd1);
    compare_all("b2b_model");

    // Output stall: first k-mer must hold while downstream is not ready.
    ready_mode = 2;
    str_to_seq(64'("ACGTA"), 5);
    add_seq();
    fork
      run("hold", 0);
      begin
        for (int c = 0; c < 20 && !kmer_valid; c++) @(negedge clk);
        check("hold_valid", 32'(kmer_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check($sformatf("hold_base_ready%0d", c), 32'(base_ready), 32'd0);
          check($sformatf("hold_kmer%0d", c), kmer, 32'h1B);
        end
        ready_mode = 0;
      end
    join
    check("hold_count", 32'(got.size()), 32'd2);
    compare_all("hold_model");

    // Position counter wrap over a long homopolymer run.
    for (int i = 0; i < 70000; i++) seq_tmp.push_back(2'd1);
    add_seq();
    run("wrap", 0);
    check("wrap_count", 32'(got.size()), 32'd69997);
    if (got.size() > 65536) begin
      check("wrap_pos_ffff", 32'(got[65535].pos), 32'h0000FFFF);
      check("wrap_pos_0", 32'(got[65536].pos), 32'd0);
      check("wrap_kmer", got[65536].kmer, 32'h55);
    end
    compare_all("wrap_model");

    // Asynchronous reset while a k-mer is pending.
    ready_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      base_valid = 1'b1;
      base       = 2'(i);
      base_last  = 1'b0;
      @(posedge clk); #1;
    end
    base_valid = 1'b0;
    @(negedge clk);
    check("mid_pre_valid", 32'(kmer_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(kmer_valid), 32'd0);
    check("mid_rst_kmer", kmer, 32'd0);
    check("mid_rst_ready", 32'(base_ready), 32'd1);
    ready_mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    str_to_seq(64'("GTAC"), 4);
    add_seq();
    run("post_rst", 0);
    check("post_rst_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      check("post_rst_kmer", got[0].kmer, 32'hB1);
      check("post_rst_pos", 32'(got[0].pos), 32'd0);
    end
    compare_all("post_rst_model");

    // Random back-to-back sequences with input gaps and output backpressure.
    ready_mode = 1;
    for (int s = 0; s < 10; s++) begin
      int len;
      len = int'($urandom_range(30, 1));
      for (int i = 0; i < len; i++) seq_tmp.push_back(2'($urandom_range(3)));
      add_seq();
    end
    run("random", 25);
    ready_mode = 0;
    compare_all("random_model");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proj_kmer_extractor.md
Name: proj_kmer_extractor

Overview:
- Upstream stage of proj_hasher.
- Consumes a stream of 2-bit DNA bases and maintains a sliding window of KMER_LEN bases.
- For every window position of a sequence, emits one k-mer, zero-extended to HASHER_DATA_BITS, as the `kmer` operand of the hasher.
- Output is a single registered valid/ready stage; sequences are delimited by a last flag.

Parameters:
- KMER_LEN, 4, bases per k-mer; legal range 2..HASHER_DATA_BITS/DATA_BITS.
- DATA_BITS, 2, bits per base; encoding A=0, C=1, G=2, T=3.
- HASHER_DATA_BITS, 32, width of the k-mer word delivered to the hasher.
- POS_BITS, 16, width of the k-mer position counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- base_valid  in  1  upstream base present.
- base_ready  out  1  block accepts a base this cycle.
- base  in  DATA_BITS  base code.
- base_last  in  1  base is the final base of its sequence.
- kmer_valid  out  1  k-mer output valid.
- kmer_ready  in  1  downstream (hasher feed) accepts the k-mer.
- kmer  out  HASHER_DATA_BITS  k-mer; bits [KMER_LEN*DATA_BITS-1:0] used, upper bits 0.
- kmer_pos  out  POS_BITS  index of the k-mer's first base within its sequence.
- kmer_last  out  1  k-mer contains the sequence's last base.
- seq_short  out  1  one-cycle pulse: sequence ended with fewer than KMER_LEN bases.

Behaviour:
- Reset (asynchronous, rst_n low) clears all state and outputs:
  - kmer_valid=0, kmer=0, kmer_pos=0, kmer_last=0, seq_short=0.
  - Window cleared, fill count 0, state FILL.
  - base_ready is combinational, so it reads 1 out of reset.
- Handshakes:
  - Base accepted when base_valid && base_ready.
  - base_ready = !kmer_valid || kmer_ready.
  - K-mer transferred when kmer_valid && kmer_ready.
  - kmer, kmer_pos and kmer_last hold stable while kmer_valid && !kmer_ready.
- Window shift on each accepted base: window = {window[W-DATA_BITS-1:0], base}, with W = KMER_LEN*DATA_BITS. The newest base is at the LSBs; the oldest base is at the MSBs.
- State FILL (fill count c < KMER_LEN-1):
  - Accepted base, not last: c++.
  - If c reaches KMER_LEN-1 on this base: next accept goes to STREAM handling. Precisely: on the KMER_LEN-th accepted base, go to STREAM and emit.
  - Accepted base with base_last while still short: seq_short=1 next cycle only, no k-mer emitted, window and c cleared, stay in FILL.
- State STREAM: every accepted base registers a new output next cycle:
  - kmer_valid=1, kmer = zero-extended window.
  - kmer_pos = current position counter; the counter then increments, wrapping modulo 2^POS_BITS.
  - kmer_last = base_last.
  - On base_last: clear window, c and the position counter; return to FILL.
- Latency: 1 cycle from the accept of the completing base to kmer_valid.
- Throughput: 1 k-mer per cycle under continuous ready.
- If a transfer and a new accept happen in the same cycle, the output register reloads with no bubble.
- kmer_valid drops the cycle after a transfer when no new k-mer is produced.
- A sequence of exactly KMER_LEN bases yields one k-mer with kmer_last=1 and kmer_pos=0.
- A single-base sequence with KMER_LEN=1 is illegal by parameter range.
- Back-to-back sequences: the first base after a last starts a fresh fill with no idle cycle.

Optional Feature:
- Macro: PROJ_CANONICAL_KMER_EN.
- Defined:
  - A reverse-complement window is maintained in parallel: rc = {(3-base), rc[W-1:DATA_BITS]}.
  - Output kmer = unsigned min(window, rc).
  - rc is cleared exactly as the window is.
- Undefined: kmer = forward window; no rc logic is generated.

Decomposition:
- proj_pkg holds KMER_LEN, BASE_LEN (=DATA_BITS), HASHER_SORTER_SIGNATURE (=32), the POS_BITS constant, and a base_t typedef with enum values A/C/G/T.
- One sub-module, proj_kmer_revcomp: combinational complement-reverse and min select, instantiated only under PROJ_CANONICAL_KMER_EN.

Test Plan (KMER_LEN=4):
- Reset then A,C,G,T,A(last), ready=1 → two k-mers:
  - 0x0000001B, pos 0, last=0;
  - 0x0000006C, pos 1, last=1.
- Same stream with PROJ_CANONICAL_KMER_EN → 0x1B (self-revcomp), then min(0x6C, 0xC6) = 0x6C.
- A,C,G(last) → seq_short pulses 1 cycle, no kmer_valid; a following T,T,T,T(last) → 0xFF, pos 0, last=1.
- Hold kmer_ready=0 for 5 cycles after the first k-mer → base_ready=0, kmer stable at 0x1B. Release → remaining k-mers in order, none lost or duplicated.
- 70000-base sequence of C → kmer_pos wraps from 0xFFFF to 0x0000, and all k-mers are 0x55.
- Assert rst_n low mid-stream with kmer_valid=1 → outputs clear immediately. Next sequence starts at pos 0 and needs a full 4-base fill.
